// File: rtl/sd_spi_pkg.sv
// Shared constants, state type and frame helpers for the SD SPI-mode command path.
package sd_spi_pkg;

    localparam logic [6:0] CRC7_POLY    = 7'h09;
    localparam logic       START_BIT    = 1'b0;
    localparam logic       TX_BIT       = 1'b1;
    localparam logic       END_BIT      = 1'b1;
    localparam logic [7:0] FILL_DEFAULT = 8'hFF;
    localparam int         HDR_W        = 40;
    localparam int         FRAME_LEN    = 6;

    typedef enum logic [2:0] {
        IDLE,
        CRC,
        SEND,
        POLL,
        DONE
    } seq_state_t;

    // Byte k of the 6-byte command frame; the last byte carries CRC7 and the end bit.
    function automatic logic [7:0] frame_byte(
        input logic [HDR_W-1:0] hdr,
        input logic [6:0]       crc,
        input logic [2:0]       k
    );
        logic [7:0] b;
        case (k)
            3'd0:    b = hdr[39:32];
            3'd1:    b = hdr[31:24];
            3'd2:    b = hdr[23:16];
            3'd3:    b = hdr[15:8];
            3'd4:    b = hdr[7:0];
            default: b = {crc, END_BIT};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, zero initial value, no final XOR.
module crc7_serial
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] r_crc;
    logic       w_fb;
    logic [6:0] w_crc_next;

    assign w_fb       = bit_in ^ r_crc[6];
    assign w_crc_next = {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 7'h00;
        end else if (clr) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Runs one SD SPI-mode command: CRC7 over the header, 6-byte frame out,
// then fill-byte polling until an R1 byte (bit 7 clear) or NCR_MAX polls.
module sd_cmd_sequencer
    import sd_spi_pkg::*;
#(
    parameter int unsigned NCR_MAX = 8,
    parameter logic [7:0]  FILL    = FILL_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        busy,
    output logic        resp_valid,
    output logic [7:0]  resp,
    output logic        resp_timeout
);

    localparam logic [5:0] CNT_LAST  = 6'(HDR_W - 1);
    localparam logic [2:0] BYTE_LAST = 3'(FRAME_LEN - 1);
    localparam logic [7:0] NCR_LAST  = 8'(NCR_MAX);

    seq_state_t         r_state;
    logic [HDR_W-1:0]   r_hdr;
    logic [5:0]         r_cnt;
    logic [2:0]         r_byte;
    logic [7:0]         r_poll;
    logic               r_wait;
    logic [7:0]         r_tx_data;
    logic               r_tx_valid;
    logic               r_resp_valid;
    logic [7:0]         r_resp;
    logic               r_resp_timeout;
    logic               r_busy;
    logic               r_cmd_ready;

    logic               w_accept;
    logic               w_crc_en;
    logic [6:0]         w_crc;
    logic [HDR_W-1:0]   w_rot;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_crc_en = (r_state == CRC);

    // Rotating rather than shifting leaves the header intact after 40 steps,
    // so the same register feeds the CRC and the outgoing frame bytes.
    assign w_rot = {r_hdr[HDR_W-2:0], r_hdr[HDR_W-1]};

    crc7_serial u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_accept),
        .en     (w_crc_en),
        .bit_in (r_hdr[HDR_W-1]),
        .crc    (w_crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_hdr          <= '0;
            r_cnt          <= '0;
            r_byte         <= '0;
            r_poll         <= '0;
            r_wait         <= 1'b0;
            r_tx_data      <= 8'h00;
            r_tx_valid     <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp         <= 8'hFF;
            r_resp_timeout <= 1'b0;
            r_busy         <= 1'b0;
            r_cmd_ready    <= 1'b1;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_hdr       <= {START_BIT, TX_BIT, cmd_index, cmd_arg};
                        r_cnt       <= '0;
                        r_byte      <= '0;
                        r_poll      <= '0;
                        r_wait      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= CRC;
                    end
                end

                CRC: begin
                    r_hdr <= w_rot;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_byte     <= '0;
                        r_wait     <= 1'b0;
                        r_tx_data  <= w_rot[HDR_W-1 -: 8];
                        r_tx_valid <= 1'b1;
                        r_state    <= SEND;
                    end
                end

                SEND: begin
                    if (!r_wait) begin
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_wait     <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        r_wait     <= 1'b0;
                        r_tx_valid <= 1'b1;
                        if (r_byte == BYTE_LAST) begin
                            r_poll    <= 8'd1;
                            r_tx_data <= FILL;
                            r_state   <= POLL;
                        end else begin
                            r_byte    <= r_byte + 3'd1;
                            r_tx_data <= frame_byte(r_hdr, w_crc, r_byte + 3'd1);
                        end
                    end
                end

                POLL: begin
                    if (!r_wait) begin
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_wait     <= 1'b1;
                        end
                    end else if (rx_valid) begin
                        r_wait <= 1'b0;
                        if (!rx_data[7]) begin
                            r_resp         <= rx_data;
                            r_resp_timeout <= 1'b0;
                            r_resp_valid   <= 1'b1;
                            r_state        <= DONE;
                        end else if (r_poll == NCR_LAST) begin
                            r_resp         <= 8'hFF;
                            r_resp_timeout <= 1'b1;
                            r_resp_valid   <= 1'b1;
                            r_state        <= DONE;
                        end else begin
                            r_poll     <= r_poll + 8'd1;
                            r_tx_valid <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end

                default: begin
                    r_tx_valid  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign busy         = r_busy;
    assign resp_valid   = r_resp_valid;
    assign resp         = r_resp;
    assign resp_timeout = r_resp_timeout;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: an SPI byte-engine model with random
// stalls plus a reference frame/response model built from CRC7 long division.
module tb_sd_cmd_sequencer;

    localparam int         NCR   = 8;
    localparam logic [7:0] FILLB = 8'hFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        resp_valid;
    logic [7:0]  resp;
    logic        resp_timeout;

    sd_cmd_sequencer #(.NCR_MAX(NCR), .FILL(FILLB)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp         (resp),
        .resp_timeout (resp_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [7:0]  q_tx[$];
    logic [7:0]  q_poll[$];
    int          stall_max = 0;
    int          rx_dly_max = 0;
    int          rx_cd = 0;
    int          stall_left = 0;
    int          last_rx_cyc = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [7:0]  next_rx = 8'h00;
    logic [47:0] last_frame;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of H(x)*x^7 divided by x^7+x^3+1 (0x89).
    function automatic logic [6:0] crc7_ref(input logic [39:0] h);
        logic [46:0] v;
        v = {h, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    // SPI byte-engine model: random tx_ready stalls, delayed rx strobes.
    initial begin
        tx_ready = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_cd      = 0;
                rx_valid   = 1'b0;
                stall_left = 0;
                prev_hold  = 1'b0;
                tx_ready   = 1'b1;
            end else begin
                rx_valid = 1'b0;
                if (rx_cd > 0) begin
                    rx_cd--;
                    if (rx_cd == 0) begin
                        rx_valid    = 1'b1;
                        rx_data     = next_rx;
                        last_rx_cyc = cyc;
                    end
                end
                if (prev_hold) begin
                    chk("tx_valid_held", 64'(tx_valid), 64'(1));
                    chk("tx_data_stable", 64'(tx_data), 64'(prev_data));
                end
                if (tx_valid && stall_left > 0) begin
                    tx_ready = 1'b0;
                    stall_left--;
                end else begin
                    tx_ready = 1'b1;
                end
                if (tx_valid && tx_ready) begin
                    q_tx.push_back(tx_data);
                    if (q_tx.size() > 6)
                        next_rx = (q_poll.size() > 0) ? q_poll.pop_front() : 8'hFF;
                    else
                        next_rx = 8'($urandom);
                    rx_cd      = 1 + int'($urandom_range(0, rx_dly_max));
                    stall_left = int'($urandom_range(0, stall_max));
                    prev_hold  = 1'b0;
                end else begin
                    prev_hold = tx_valid;
                    prev_data = tx_data;
                end
            end
        end
    end

    // Issue one command from a negedge; poll responses come from q_poll.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit poke);
        logic [39:0] h;
        logic [47:0] exp_f;
        logic [47:0] got_f;
        logic [7:0]  exp_resp;
        logic [7:0]  b;
        logic        exp_to;
        int          exp_polls;
        int          n;
        int          first_tx;
        bit          done;
        bit          poked;

        h         = {2'b01, idx, arg};
        exp_f     = {h, crc7_ref(h), 1'b1};
        exp_to    = 1'b1;
        exp_resp  = 8'hFF;
        exp_polls = NCR;
        for (int i = 0; i < NCR; i++) begin
            b = (i < q_poll.size()) ? q_poll[i] : 8'hFF;
            if (!b[7]) begin
                exp_resp  = b;
                exp_to    = 1'b0;
                exp_polls = i + 1;
                break;
            end
        end
        q_tx.delete();

        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_seen", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
        chk("accept_busy", 64'(busy), 64'(1));
        chk("accept_ready_low", 64'(cmd_ready), 64'(0));

        first_tx = -1;
        done     = 1'b0;
        poked    = 1'b0;
        n        = 1;
        while (!done && n < 3000) begin
            cmd_valid = 1'b0;
            if (first_tx < 0 && tx_valid) first_tx = n;
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                if (poke && (n == 10 || (!poked && q_tx.size() >= 7 && busy))) begin
                    cmd_valid = 1'b1;
                    if (n != 10) poked = 1'b1;
                end
                @(negedge clk);
                n++;
            end
        end
        cmd_valid = 1'b0;

        chk("resp_seen", 64'(done), 64'(1));
        chk("first_tx_cycle", 64'(first_tx), 64'(41));
        chk("resp", 64'(resp), 64'(exp_resp));
        chk("resp_timeout", 64'(resp_timeout), 64'(exp_to));
        chk("resp_after_rx", 64'(cyc - last_rx_cyc), 64'(1));
        chk("byte_count", 64'(q_tx.size()), 64'(6 + exp_polls));
        got_f = '0;
        for (int i = 0; i < 6; i++)
            got_f = {got_f[39:0], (i < q_tx.size()) ? q_tx[i] : 8'hXX};
        chk("frame", 64'(got_f), 64'(exp_f));
        for (int i = 6; i < q_tx.size(); i++)
            chk("fill_byte", 64'(q_tx[i]), 64'(FILLB));
        if (stall_max == 0 && rx_dly_max == 0)
            chk("best_case_cycles", 64'(n), 64'(41 + 2 * (6 + exp_polls)));
        last_frame = got_f;
        q_poll.delete();

        @(negedge clk);
        chk("resp_valid_pulse", 64'(resp_valid), 64'(0));
        chk("ready_after_done", 64'(cmd_ready), 64'(1));
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("resp_held", 64'(resp), 64'(exp_resp));
        chk("timeout_held", 64'(resp_timeout), 64'(exp_to));
    endtask

    initial begin
        int n;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("rst_tx_data", 64'(tx_data), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp", 64'(resp), 64'(8'hFF));
        chk("rst_resp_timeout", 64'(resp_timeout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // CMD0: one busy poll then R1 0x01; stray cmd_valid during CRC and POLL.
        q_poll = '{8'hFF, 8'h01};
        run_cmd(6'd0, 32'h0, 1'b1);
        chk("cmd0_frame_lit", 64'(last_frame), 64'(48'h40_00_00_00_00_95));

        // CMD8 issued back-to-back; R1 on the first poll.
        q_poll = '{8'h01};
        run_cmd(6'd8, 32'h0000_01AA, 1'b0);
        chk("cmd8_frame_lit", 64'(last_frame), 64'(48'h48_00_00_01_AA_87));

        // No response at all: NCR_MAX fill bytes then timeout.
        run_cmd(6'd55, $urandom, 1'b0);

        // Random commands with stalls and delayed rx strobes.
        stall_max  = 5;
        rx_dly_max = 4;
        for (int t = 0; t < 6; t++) begin
            int len;
            len = int'($urandom_range(0, 10));
            for (int j = 0; j < len; j++)
                q_poll.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF);
            run_cmd(6'($urandom), $urandom, t[0]);
        end

        // Reset while byte 3 of the frame is on the bus.
        stall_max  = 0;
        rx_dly_max = 0;
        cmd_valid  = 1'b1;
        cmd_index  = 6'd17;
        cmd_arg    = 32'h1122_3344;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(tx_valid && tx_data == 8'h33) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("byte3_reached", 64'(tx_data), 64'(8'h33));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_tx_valid", 64'(tx_valid), 64'(0));
        chk("midrst_tx_data", 64'(tx_data), 64'(0));
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("midrst_resp", 64'(resp), 64'(8'hFF));
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_tx_valid", 64'(tx_valid), 64'(0));

        q_poll = '{8'h01};
        run_cmd(6'd0, 32'h0, 1'b0);
        chk("postrst_cmd0_frame", 64'(last_frame), 64'(48'h40_00_00_00_00_95));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/sd_cmd_sequencer.md
# sd_cmd_sequencer

Sequences one SD-card SPI-mode command transaction: accepts a command index and 32-bit argument, computes CRC7 over the 40-bit header with a bit-serial CRC engine, streams the 6-byte frame to the SPI byte engine, then polls with fill bytes until an R1 response (bit 7 = 0) or a timeout. It sits between the SD initialisation/read FSM and the SPI byte transceiver. It is the sole user of the CRC7 datapath in the SD path.

## Interface
- `NCR_MAX`, 8: maximum poll bytes sent after the frame before timeout (1..255).
- `FILL`, 8'hFF: byte transmitted while polling.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on `cmd_valid && cmd_ready`.
- `cmd_index`  in  6  command index; sampled at acceptance.
- `cmd_arg`  in  32  argument; sampled at acceptance.
- `tx_data`  out  8  byte to SPI engine.
- `tx_valid`  out  1  `tx_data` valid; held until `tx_ready`.
- `tx_ready`  in  1  SPI engine accepts the byte.
- `rx_data`  in  8  byte received during the last accepted transfer.
- `rx_valid`  in  1  one-cycle strobe marking completion of the accepted transfer.
- `busy`  out  1  high in every state except IDLE.
- `resp_valid`  out  1  one-cycle pulse at transaction end.
- `resp`  out  8  R1 byte, or 8'hFF on timeout; held until the next `resp_valid`.
- `resp_timeout`  out  1  qualifies `resp`; held with it.

## Operation
- Header H[39:0] = {1'b0, 1'b1, cmd_index, cmd_arg}. Frame = H, then byte {crc7[6:0], 1'b1}, sent MSB byte first.
- CRC7 polynomial x^7+x^3+1, initial value 0, no reflection, no final XOR. One header bit per clock, MSB first: fb = bit ^ crc[6]; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 0).
- States:
  - IDLE: on accept, latch H, clear CRC and counters, go to CRC.
  - CRC: 40 cycles, then go to SEND.
  - SEND: present byte k (k = 0..5); after `tx_ready` handshake, drop `tx_valid` and wait for `rx_valid`. Discard `rx_data`. When k = 5, go to POLL; otherwise advance k.
  - POLL: send `FILL`, then wait for `rx_valid`.
    - If `rx_data[7]`=0: `resp`=rx_data, `resp_timeout`=0, go to DONE.
    - Else if the poll count equals `NCR_MAX`: `resp`=8'hFF, `resp_timeout`=1, go to DONE.
    - Else poll again.
  - DONE: pulse `resp_valid`, return to IDLE.
- `rx_valid` is ignored outside the wait phase of SEND/POLL. `tx_ready` is ignored while `tx_valid`=0.
- Reset, including mid-transaction, forces IDLE immediately.
  - Reset values: `tx_valid`=0, `tx_data`=0, `resp_valid`=0, `resp`=8'hFF, `resp_timeout`=0, `busy`=0.
  - `cmd_ready`=1 once reset deasserts.
  - No partial frame resumes after reset.
- `cmd_valid` while busy is not accepted. The requester holds it; no queueing.

## Timing
- Acceptance at cycle T. CRC runs T+1..T+40. `tx_valid` with byte 0 rises at T+41.
- After `rx_valid` at cycle R, the next `tx_valid` rises at R+1.
- Best case with `tx_ready` tied high and `rx_valid` one cycle after the handshake: 2 cycles per byte.
- `resp_valid` rises one cycle after the deciding `rx_valid`. `cmd_ready` rises the cycle after `resp_valid`.
- `tx_data` is stable whenever `tx_valid`=1.

## Structure
- Package `sd_spi_pkg` holds:
  - CRC7 polynomial constant 7'h09;
  - start/transmission bit constants;
  - default `FILL`;
  - header width 40 and frame length 6;
  - state enum `seq_state_t` {IDLE, CRC, SEND, POLL, DONE}.
- Sub-module `crc7_serial` (clk, rst, clr, en, bit_in, crc[6:0]) is instantiated once. The sequencer owns the header shift register and all counters.

## Test plan
- CMD0, arg 0 -> bytes 40 00 00 00 00 95; SPI model returns 0xFF, 0x01 during polls -> `resp`=0x01, `resp_timeout`=0, two poll bytes sent.
- CMD8, arg 0x000001AA -> bytes 48 00 00 01 AA 87; R1 0x01 on the first poll -> `resp`=0x01.
- Model always returns 0xFF -> exactly `NCR_MAX` (8) FILL bytes sent, then `resp`=0xFF and `resp_timeout`=1.
- `tx_ready` randomly stalled 0–5 cycles and `rx_valid` delayed -> byte order and values unchanged, `tx_data` stable while `tx_valid`, one `rx_valid` consumed per byte.
- Assert `rst` during SEND byte 3 -> the next cycle shows IDLE, `tx_valid`=0, `busy`=0. A new CMD0 after release produces a full, correct frame.
- `cmd_valid` pulsed during CRC/POLL -> not accepted and the current transaction completes unchanged. A back-to-back command is accepted the cycle `cmd_ready` rises.
